// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC, direct-mapped one-word-per-line I-cache and decoder output register
// Optional cache storage is built only when ICACHE_EN is defined; otherwise every fetch reads memory.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC          = 32'h0,
    parameter int          ICACHE_INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rdy,
    input  logic [31:0] mem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        dec_ready
);
    typedef enum logic {S_FETCH, S_WAIT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic        accept;
    logic        buf_free;
    logic        hit;
    logic [31:0] hit_word;

    assign accept   = inst_valid & dec_ready;
    assign buf_free = ~inst_valid | accept;

`ifdef ICACHE_EN
    localparam int ENTRIES = 1 << ICACHE_INDEX_BITS;
    localparam int TAG_W   = 30 - ICACHE_INDEX_BITS;

    logic [ENTRIES-1:0]           line_valid;
    logic [TAG_W-1:0]             line_tag  [ENTRIES];
    logic [31:0]                  line_data [ENTRIES];
    logic [ICACHE_INDEX_BITS-1:0] pc_index;
    logic [TAG_W-1:0]             pc_tag;
    logic                         fill;

    assign pc_index = pc[ICACHE_INDEX_BITS+1:2];
    assign pc_tag   = pc[31:ICACHE_INDEX_BITS+2];
    assign hit      = line_valid[pc_index] && (line_tag[pc_index] == pc_tag);
    assign hit_word = line_data[pc_index];
    // A read completing under flush is dropped, so it must not allocate either.
    assign fill     = rdy_in & ~flush & (state == S_WAIT) & mem_rdy;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            line_valid <= '0;
        end else if (fill) begin
            line_valid[pc_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            line_tag[pc_index]  <= pc_tag;
            line_data[pc_index] <= mem_data;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else if (rdy_in) begin
            if (flush) begin
                pc         <= flush_pc;
                inst_valid <= 1'b0;
                mem_en     <= 1'b0;
                state      <= S_FETCH;
            end else begin
                if (accept) begin
                    inst_valid <= 1'b0;
                end
                case (state)
                    S_FETCH: begin
                        if (buf_free) begin
                            if (hit) begin
                                inst       <= hit_word;
                                inst_pc    <= pc;
                                inst_valid <= 1'b1;
                                pc         <= pc + 32'd4;
                            end else begin
                                mem_en   <= 1'b1;
                                mem_addr <= pc;
                                state    <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        // Buffer is always empty here, so the returned word goes straight out.
                        if (mem_rdy) begin
                            inst       <= mem_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            pc         <= pc + 32'd4;
                            mem_en     <= 1'b0;
                            state      <= S_FETCH;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch; ICACHE_EN selects cached expectations
`timescale 1ns/1ps
module tb_instruction_fetch;
`ifdef ICACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    localparam int LAT = 3;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush, mem_rdy, dec_ready;
    logic [31:0] flush_pc, mem_data;
    logic        mem_en, inst_valid;
    logic [31:0] mem_addr, inst, inst_pc;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          lat_cnt = 0;
    bit          mem_auto = 1'b1;
    logic        prev_en = 1'b0;
    logic [63:0] exp_q[$];
    int          acc_cyc[$];
    logic [31:0] req_log[$];

    instruction_fetch #(.RESET_PC(32'h0), .ICACHE_INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .flush_pc(flush_pc),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdy(mem_rdy), .mem_data(mem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .dec_ready(dec_ready)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1357_0000 ^ a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_q.push_back({a, mem_word(a)});
    endtask

    // Decoder-side monitor and request logger.
    always @(negedge clk_in) begin
        logic [63:0] e;
        if (!rst_in && rdy_in && !flush && inst_valid && dec_ready) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got pc %h word %h, expected none", inst_pc, inst);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e[63:32]);
                check("inst_word", inst, e[31:0]);
            end
        end
        if (!rst_in && mem_en && !prev_en) req_log.push_back(mem_addr);
        prev_en = rst_in ? 1'b0 : mem_en;
    end

    // One clock; the memory model with fixed latency answers at posedge+1, stimulus resumes at posedge+2.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (mem_auto) begin
            if (!rst_in && mem_en && !mem_rdy) begin
                lat_cnt++;
                if (lat_cnt == LAT) begin
                    mem_rdy  = 1'b1;
                    mem_data = mem_word(mem_addr);
                end
            end else begin
                mem_rdy  = 1'b0;
                mem_data = '0;
                lat_cnt  = 0;
            end
        end
        #1;
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_cnt < target && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (acc_cnt < target) begin
            miscompares++;
            $display("FAIL %s: timeout with %0d accepts, expected %0d", name, acc_cnt, target);
        end
    endtask

    task automatic wait_high(input bit sel_rdy, input string name);
        int n = 0;
        while (!(sel_rdy ? mem_rdy : inst_valid) && n < 50) begin
            tick();
            n++;
        end
        check(name, {31'b0, (sel_rdy ? mem_rdy : inst_valid)}, 32'd1);
    endtask

    function automatic int count_req(input int from, input logic [31:0] lo, input logic [31:0] hi);
        int n = 0;
        for (int i = from; i < req_log.size(); i++)
            if (req_log[i] >= lo && req_log[i] <= hi) n++;
        return n;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        int target;
        logic [31:0] alias_addr [4];
        alias_addr[0] = 32'h100; alias_addr[1] = 32'h000;
        alias_addr[2] = 32'h100; alias_addr[3] = 32'h000;

        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; flush_pc = '0;
        mem_rdy = 1'b0; mem_data = '0; dec_ready = 1'b0;
        tick(); tick();
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // First miss after reset, 3-cycle memory.
        rst_in = 1'b0;
        tick();
        check("first_req_en", {31'b0, mem_en}, 32'd1);
        check("first_req_addr", mem_addr, 32'h0);
        push_exp(32'h0);
        repeat (3) tick();
        check("first_inst_valid", {31'b0, inst_valid}, 32'd1);
        check("first_inst_pc", inst_pc, 32'h0);
        check("first_en_drop", {31'b0, mem_en}, 32'd0);
        dec_ready = 1'b1;
        tick();
        check("second_req_en", {31'b0, mem_en}, 32'd1);
        check("second_req_addr", mem_addr, 32'h4);
        push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        wait_acc(4, "pass1");

        // Second pass over the loop.
        m = req_log.size();
        flush = 1'b1; flush_pc = 32'h0;
        for (int a = 0; a < 16; a += 4) push_exp(a);
        tick();
        flush = 1'b0;
        wait_acc(8, "pass2");
        for (int i = 5; i < 8; i++)
            check($sformatf("pass2_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], CACHE ? 32'd1 : LAT + 1);
        check("pass2_loop_reqs", count_req(m, 32'h0, 32'hC), CACHE ? 32'd0 : 32'd4);

        // Backpressure.
        dec_ready = 1'b0;
        flush = 1'b1; flush_pc = 32'h0;
        push_exp(32'h0);
        tick();
        flush = 1'b0;
        wait_high(1'b0, "bp_fill");
        m = req_log.size();
        repeat (5) begin
            tick();
            check("bp_hold_valid", {31'b0, inst_valid}, 32'd1);
            check("bp_hold_pc", inst_pc, 32'h0);
            check("bp_hold_inst", inst, mem_word(32'h0));
        end
        check("bp_no_req", req_log.size() - m, 32'd0);
        check("bp_no_en", {31'b0, mem_en}, 32'd0);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check("bp_next_valid", {31'b0, inst_valid}, {31'b0, CACHE});
        check("bp_next_pc", CACHE ? inst_pc : mem_addr, 32'h4);

        // Flush coinciding with mem_rdy.
        flush = 1'b1; flush_pc = 32'h40;
        tick();
        flush = 1'b0;
        wait_high(1'b1, "flushrdy_wait");
        check("flushrdy_addr", mem_addr, 32'h40);
        flush = 1'b1; flush_pc = 32'h200;
        tick();
        flush = 1'b0;
        check("flushrdy_valid", {31'b0, inst_valid}, 32'd0);
        check("flushrdy_en", {31'b0, mem_en}, 32'd0);
        tick();
        check("flushrdy_next_en", {31'b0, mem_en}, 32'd1);
        check("flushrdy_next_addr", mem_addr, 32'h200);
        m = req_log.size();
        target = acc_cnt + 1;
        flush = 1'b1; flush_pc = 32'h40; dec_ready = 1'b1;
        push_exp(32'h40);
        tick();
        flush = 1'b0;
        wait_acc(target, "refetch40");
        dec_ready = 1'b0;
        check("refetch40_reqs", count_req(m, 32'h40, 32'h40), 32'd1);

        // Aliasing on index 0.
        m = req_log.size();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) m = req_log.size();
            target = acc_cnt + 1;
            flush = 1'b1; flush_pc = alias_addr[i]; dec_ready = 1'b1;
            push_exp(alias_addr[i]);
            tick();
            flush = 1'b0;
            wait_acc(target, "alias");
            dec_ready = 1'b0;
        end
        check("alias_misses", count_req(m, 32'h0, 32'h0) + count_req(m, 32'h100, 32'h100), 32'd3);

        // Freeze mid-WAIT with mem_rdy pulsing, then async reset mid-WAIT.
        mem_auto = 1'b0; mem_rdy = 1'b0; mem_data = '0;
        flush = 1'b1; flush_pc = 32'h300;
        tick();
        flush = 1'b0;
        tick();
        check("frz_req_en", {31'b0, mem_en}, 32'd1);
        check("frz_req_addr", mem_addr, 32'h300);
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rdy = (i % 2 == 0);
            mem_data = 32'hDEAD_0000 + i;
            tick();
            check("frz_hold_en", {31'b0, mem_en}, 32'd1);
            check("frz_hold_addr", mem_addr, 32'h300);
            check("frz_hold_valid", {31'b0, inst_valid}, 32'd0);
        end
        rdy_in = 1'b1; mem_rdy = 1'b0;
        tick();
        check("frz_still_en", {31'b0, mem_en}, 32'd1);
        mem_rdy = 1'b1; mem_data = mem_word(32'h300); dec_ready = 1'b1;
        push_exp(32'h300);
        tick();
        mem_rdy = 1'b0; mem_data = '0;
        check("frz_done_valid", {31'b0, inst_valid}, 32'd1);
        check("frz_done_en", {31'b0, mem_en}, 32'd0);
        check("frz_done_pc", inst_pc, 32'h300);
        tick();
        dec_ready = 1'b0;
        check("pre_rst_en", {31'b0, mem_en}, 32'd1);
        check("pre_rst_addr", mem_addr, 32'h304);
        #1 rst_in = 1'b1;
        #1;
        check("async_rst_en", {31'b0, mem_en}, 32'd0);
        check("async_rst_addr", mem_addr, 32'd0);
        tick();
        check("sb_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the memory controller's decoder port.
- Holds the PC and looks up a direct-mapped, one-word-per-line instruction cache.
- On a miss, issues a word read through the controller's enable/address/ready handshake.
- Presents one instruction at a time to the decoder through a valid/ready output register; flush redirects the PC.

Parameters:
- RESET_PC, 32'h0, PC value loaded at reset.
- ICACHE_INDEX_BITS, 6, log2 of cache entry count (64 entries of one 32-bit word each).

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset
- rdy_in  input  1  global enable; low freezes all state
- flush  input  1  redirect request
- flush_pc  input  32  new PC, sampled when flush=1
- mem_en  output  1  read request to memory controller
- mem_addr  output  32  word address of request
- mem_rdy  input  1  request complete; mem_data valid this cycle only
- mem_data  input  32  fetched instruction word
- inst_valid  output  1  instruction register holds a valid instruction
- inst  output  32  instruction word
- inst_pc  output  32  PC of inst
- dec_ready  input  1  decoder accepts inst this cycle

Behaviour:
- Clock and reset:
  - Single clock, clk_in.
  - Reset rst_in is asynchronous, active-high.
  - On reset: pc=RESET_PC, state=FETCH, mem_en=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0, all cache valid bits=0.
  - Reset mid-miss abandons the request immediately.
- Freeze: when rdy_in=0, no register changes and outputs hold.
- Address split:
  - index = pc[ICACHE_INDEX_BITS+1:2]
  - tag = pc[31:ICACHE_INDEX_BITS+2]
  - pc[1:0] is always 0 and is not stored.
- Consume: "accept" = inst_valid & dec_ready. Accept alone clears inst_valid at the edge.
- Buffer free: inst_valid=0 or accept.
- State FETCH, only acts when the buffer is free:
  - Hit (valid[index] and tag match): inst<=cached word, inst_pc<=pc, inst_valid<=1, pc<=pc+4, stay in FETCH. One instruction per cycle sustained on hits.
  - Miss: mem_en<=1, mem_addr<=pc, go to WAIT. inst_valid is 0 at the end of this edge.
- State WAIT:
  - mem_en and mem_addr are held stable until mem_rdy.
  - On mem_rdy: write cache entry (valid=1, tag, mem_data); inst<=mem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4, mem_en<=0, go to FETCH.
  - mem_en drops on the same edge that inst_valid rises, so the controller never sees an extra cycle of enable.
- Miss latency: the hit on the re-fetched line is not needed. The instruction appears on the edge after mem_rdy.
- Flush (rdy_in=1) has priority over every other event, including a simultaneous mem_rdy or accept:
  - pc<=flush_pc, inst_valid<=0, mem_en<=0, state<=FETCH.
  - mem_data arriving in the flush cycle is discarded and not written to the cache.
  - Cache contents are preserved across flush.
- PC arithmetic is 32-bit and wraps: 32'hFFFFFFFC+4 = 0.
- The cache is never invalidated except by reset. Self-modifying code is unsupported.
- Conflict misses overwrite the entry. No replacement state.

Optional Feature:
- Macro: ICACHE_EN.
- Defined: cache as above.
- Undefined:
  - No cache storage is instantiated.
  - Every fetch takes the miss path (FETCH→WAIT→FETCH).
  - Throughput is one instruction per memory round trip plus one cycle.
  - Port list and handshake timing are otherwise identical.

Test Plan:
- Release reset with RESET_PC=0 and a memory model of 3-cycle latency → mem_en=1 with mem_addr=0 one cycle after release. mem_rdy on the third cycle → next edge inst_valid=1, inst_pc=0, mem_en=0, next request mem_addr=4.
- Loop 0x0–0xC executed twice via flush_pc=0 after the first pass → second pass produces no mem_en; instructions at PCs 0,4,8,C on consecutive cycles with dec_ready=1.
- Backpressure: hold dec_ready=0 for 5 cycles with inst_valid=1 → inst/inst_pc unchanged, pc does not advance, no new mem_en. dec_ready=1 → next instruction the following cycle on a hit.
- Flush in WAIT on the same cycle as mem_rdy (addr 0x40, flush_pc=0x200) → inst_valid stays 0, entry for 0x40 stays invalid, next request mem_addr=0x200.
- Aliasing with ICACHE_INDEX_BITS=6: fetch 0x000, then 0x100, then 0x000 → three misses; the third returns the memory word of 0x000 again.
- rdy_in=0 for 4 cycles mid-WAIT with mem_rdy pulsing → no state change; after rdy_in=1 the request is still held and completes normally. Async reset asserted mid-WAIT → mem_en=0 immediately, without waiting for a clock edge.
